// File: rtl/data_cache_ctrl.sv
// 2-way set-associative, write-through, no-write-allocate data cache between the MEM stage and the SRAM controller.
// Optional read hit/miss statistics are enabled with `define DCACHE_STATS_EN.
module data_cache_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int unsigned SET_BITS  = 6,
  parameter int unsigned TAG_BITS  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        read_en,
  input  logic        write_en,
  output logic [31:0] readData,
  output logic        ready,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        sram_r_en,
  output logic        sram_w_en,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int unsigned SETS = 1 << SET_BITS;

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

  state_t state, state_nx;

  logic [31:0]         eff;
  logic                word_sel;
  logic [SET_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;
  logic                unused_bits;

  assign eff      = address - BASE_ADDR;
  assign word_sel = eff[2];
  assign idx      = eff[3 +: SET_BITS];
  assign tag      = eff[3 + SET_BITS +: TAG_BITS];
  assign unused_bits = ^{eff[1:0], eff[31:3 + SET_BITS + TAG_BITS]};

  logic [SETS-1:0]     valid0, valid1, lru;
  logic [TAG_BITS-1:0] tag0  [SETS];
  logic [TAG_BITS-1:0] tag1  [SETS];
  logic [63:0]         data0 [SETS];
  logic [63:0]         data1 [SETS];

  logic        hit0, hit1, hit;
  logic [63:0] hit_line;
  logic [31:0] hit_word, sram_word;
  logic        fill_way1;

  assign hit0      = valid0[idx] && (tag0[idx] == tag);
  assign hit1      = valid1[idx] && (tag1[idx] == tag);
  assign hit       = hit0 || hit1;
  assign hit_line  = hit0 ? data0[idx] : data1[idx];
  assign hit_word  = word_sel ? hit_line[63:32] : hit_line[31:0];
  assign sram_word = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
  // An invalid way is always taken first; with both valid the LRU bit names the victim.
  assign fill_way1 = valid0[idx] ? (valid1[idx] ? lru[idx] : 1'b1) : 1'b0;

  logic fill_en, touch_en, touch_way, wr_hit_en;

  always_comb begin
    state_nx     = state;
    ready        = 1'b1;
    readData     = '0;
    sram_address = '0;
    sram_wdata   = '0;
    sram_r_en    = 1'b0;
    sram_w_en    = 1'b0;
    fill_en      = 1'b0;
    touch_en     = 1'b0;
    touch_way    = 1'b0;
    wr_hit_en    = 1'b0;
    case (state)
      IDLE: begin
        if (write_en) begin
          ready    = 1'b0;
          state_nx = WRITE;
        end else if (read_en) begin
          if (hit) begin
            readData  = hit_word;
            touch_en  = 1'b1;
            touch_way = hit1;
          end else begin
            ready    = 1'b0;
            state_nx = READ_MISS;
          end
        end
      end
      READ_MISS: begin
        sram_r_en    = 1'b1;
        sram_address = {address[31:3], 3'b000};
        ready        = 1'b0;
        if (sram_ready) begin
          ready    = 1'b1;
          readData = sram_word;
          fill_en  = 1'b1;
          state_nx = IDLE;
        end
      end
      WRITE: begin
        sram_w_en    = 1'b1;
        sram_address = address;
        sram_wdata   = writeData;
        ready        = 1'b0;
        if (sram_ready) begin
          ready    = 1'b1;
          state_nx = IDLE;
          if (hit) begin
            wr_hit_en = 1'b1;
            touch_en  = 1'b1;
            touch_way = hit1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else begin
      state <= state_nx;
      if (fill_en) begin
        if (fill_way1) valid1[idx] <= 1'b1;
        else           valid0[idx] <= 1'b1;
        lru[idx] <= ~fill_way1;
      end else if (touch_en) begin
        lru[idx] <= ~touch_way;
      end
    end
  end

  // Tag/data arrays carry no reset; valid bits gate them, and the enables are idle under reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      if (fill_way1) begin
        tag1[idx]  <= tag;
        data1[idx] <= sram_rdata;
      end else begin
        tag0[idx]  <= tag;
        data0[idx] <= sram_rdata;
      end
    end
    if (wr_hit_en) begin
      if (hit0) begin
        if (word_sel) data0[idx][63:32] <= writeData;
        else          data0[idx][31:0]  <= writeData;
      end else begin
        if (word_sel) data1[idx][63:32] <= writeData;
        else          data1[idx][31:0]  <= writeData;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic        cnt_hit, cnt_miss;
  logic [15:0] hit_q, miss_q;

  assign cnt_hit  = (state == IDLE) && !write_en && read_en && hit;
  assign cnt_miss = (state == IDLE) && !write_en && read_en && !hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (cnt_hit && (hit_q != '1))   hit_q  <= hit_q + 16'd1;
      if (cnt_miss && (miss_q != '1)) miss_q <= miss_q + 16'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Randomized self-checking bench for data_cache_ctrl: a per-set recency-list cache model plus a
// word-addressed memory model predict hit/miss, stall and data behaviour on every cycle.
`timescale 1ns/1ps
module tb_data_cache_ctrl;

  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] writeData = '0;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [31:0] readData;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_r_en;
  logic        sram_w_en;
  logic [63:0] sram_rdata;
  logic        sram_ready;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  always #5 clk = ~clk;

  data_cache_ctrl #(
    .BASE_ADDR(32'd1024),
    .SET_BITS (6),
    .TAG_BITS (10)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .address     (address),
    .writeData   (writeData),
    .read_en     (read_en),
    .write_en    (write_en),
    .readData    (readData),
    .ready       (ready),
    .sram_address(sram_address),
    .sram_wdata  (sram_wdata),
    .sram_r_en   (sram_r_en),
    .sram_w_en   (sram_w_en),
    .sram_rdata  (sram_rdata),
    .sram_ready  (sram_ready),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: SRAM contents are the truth, since the cache is write-through.
  logic [31:0] mem [int unsigned];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int unsigned w;
    w = {a[31:2], 2'b00};
    if (mem.exists(w)) return mem[w];
    return {~a[15:0], a[15:2], 2'b00};
  endfunction

  // Cache model: per set, a list of resident tags, most recently used first.
  int unsigned m_cnt [64];
  int unsigned m_tag [64][2];
  int unsigned m_hits, m_misses;

  function automatic int unsigned set_of(input logic [31:0] a);
    return int'(((a - BASE) >> 3) & 32'd63);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return int'(((a - BASE) >> 9) & 32'd1023);
  endfunction

  function automatic int m_find(input logic [31:0] a);
    int unsigned s;
    s = set_of(a);
    for (int i = 0; i < 2; i++)
      if (i < int'(m_cnt[s]) && m_tag[s][i] == tag_of(a)) return i;
    return -1;
  endfunction

  task automatic m_touch(input logic [31:0] a, input int pos);
    int unsigned s, t;
    s = set_of(a);
    if (pos == 1) begin
      t = m_tag[s][0];
      m_tag[s][0] = m_tag[s][1];
      m_tag[s][1] = t;
    end
  endtask

  task automatic m_fill(input logic [31:0] a);
    int unsigned s;
    s = set_of(a);
    m_tag[s][1] = m_tag[s][0];
    m_tag[s][0] = tag_of(a);
    if (m_cnt[s] < 2) m_cnt[s]++;
  endtask

  task automatic m_clear();
    for (int i = 0; i < 64; i++) m_cnt[i] = 0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  function automatic logic [15:0] exp_hits();
`ifdef DCACHE_STATS_EN
    return m_hits[15:0];
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic [15:0] exp_misses();
`ifdef DCACHE_STATS_EN
    return m_misses[15:0];
`else
    return 16'd0;
`endif
  endfunction

  // SRAM responder: completes each enabled operation after a random (or forced) delay.
  int unsigned fixed_delay = 0;
  initial begin : sram_model
    int unsigned wait_left;
    bit          op_active;
    logic [31:0] line;
    sram_ready = 1'b0;
    sram_rdata = '0;
    op_active  = 1'b0;
    wait_left  = 0;
    forever begin
      @(posedge clk);
      #2;
      sram_ready = 1'b0;
      if (!rst_n || !(sram_r_en || sram_w_en)) begin
        op_active = 1'b0;
      end else begin
        if (!op_active) begin
          op_active = 1'b1;
          wait_left = (fixed_delay != 0) ? fixed_delay : $urandom_range(0, 3);
        end
        if (wait_left == 0) begin
          sram_ready = 1'b1;
          op_active  = 1'b0;
          if (sram_w_en) begin
            mem[{sram_address[31:2], 2'b00}] = sram_wdata;
          end else begin
            line = {sram_address[31:3], 3'b000};
            sram_rdata = {mem_rd(line + 32'd4), mem_rd(line)};
          end
        end else begin
          wait_left--;
        end
      end
    end
  end

  // Compare process: every cycle, outputs are checked against the model's prediction.
  typedef enum {P_IDLE, P_RMISS, P_WRITE} phase_t;
  initial begin : compare
    phase_t phase;
    int     pos;
    phase = P_IDLE;
    m_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_clear();
        phase = P_IDLE;
        chk("rst_ready", ready, 1);
        chk("rst_r_en", sram_r_en, 0);
        chk("rst_w_en", sram_w_en, 0);
        chk("rst_readData", readData, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);
      end else begin
        chk("hit_count", hit_count, exp_hits());
        chk("miss_count", miss_count, exp_misses());
        case (phase)
          P_IDLE: begin
            chk("idle_r_en", sram_r_en, 0);
            chk("idle_w_en", sram_w_en, 0);
            if (write_en) begin
              chk("wr_start_ready", ready, 0);
              phase = P_WRITE;
            end else if (read_en) begin
              pos = m_find(address);
              if (pos >= 0) begin
                chk("hit_ready", ready, 1);
                chk("hit_data", readData, mem_rd(address));
                m_touch(address, pos);
                m_hits++;
              end else begin
                chk("miss_ready", ready, 0);
                m_misses++;
                phase = P_RMISS;
              end
            end else begin
              chk("noreq_ready", ready, 1);
            end
          end
          P_RMISS: begin
            chk("rmiss_r_en", sram_r_en, 1);
            chk("rmiss_w_en", sram_w_en, 0);
            chk("rmiss_addr", sram_address, {address[31:3], 3'b000});
            if (sram_ready) begin
              chk("rmiss_done_ready", ready, 1);
              chk("rmiss_data", readData, mem_rd(address));
              m_fill(address);
              phase = P_IDLE;
            end else begin
              chk("rmiss_wait_ready", ready, 0);
            end
          end
          P_WRITE: begin
            chk("write_w_en", sram_w_en, 1);
            chk("write_r_en", sram_r_en, 0);
            chk("write_addr", sram_address, address);
            chk("write_wdata", sram_wdata, writeData);
            if (sram_ready) begin
              chk("write_done_ready", ready, 1);
              pos = m_find(address);
              if (pos >= 0) m_touch(address, pos);
              phase = P_IDLE;
            end else begin
              chk("write_wait_ready", ready, 0);
            end
          end
          default: phase = P_IDLE;
        endcase
      end
    end
  end

  // Issues one request (0 none, 1 read, 2 write) starting just after a rising edge and holds it
  // until the cycle in which ready is high; returns the load data of that cycle and the stall count.
  task automatic do_req(input int kind, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int stalls);
    logic r;
    read_en   = (kind == 1);
    write_en  = (kind == 2);
    address   = a;
    writeData = d;
    stalls    = 0;
    rd        = '0;
    forever begin
      @(negedge clk);
      rd = readData;
      r  = ready;
      @(posedge clk);
      #1;
      if (r) break;
      stalls++;
      if (stalls > 60) begin
        n_checks++;
        n_err++;
        $display("FAIL req_timeout: ready still low after %0d cycles, required high", stalls);
        break;
      end
    end
    read_en  = 1'b0;
    write_en = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : stimulus
    logic [31:0] rd, a;
    int          st, r, kind;

    mem[32'h400] = 32'hAAAA0000;
    mem[32'h404] = 32'hBBBB0000;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    do_req(1, 32'h400, '0, rd, st);
    chk("tp_first_miss_data", rd, 32'hAAAA0000);
    chk("tp_first_miss_stalled", st > 0, 1);
    do_req(1, 32'h404, '0, rd, st);
    chk("tp_same_line_hit_data", rd, 32'hBBBB0000);
    chk("tp_same_line_hit_stalls", st, 0);

    do_req(1, 32'h600, '0, rd, st);
    chk("tp_fill_tag1_miss", st > 0, 1);
    do_req(1, 32'h800, '0, rd, st);
    chk("tp_fill_tag2_miss", st > 0, 1);
    do_req(1, 32'h600, '0, rd, st);
    chk("tp_tag1_hit_stalls", st, 0);
    do_req(1, 32'h400, '0, rd, st);
    chk("tp_tag0_evicted", st > 0, 1);
    chk("tp_tag0_refill_data", rd, 32'hAAAA0000);

    do_req(2, 32'h400, 32'h12345678, rd, st);
    chk("tp_store_stalled", st > 0, 1);
    do_req(1, 32'h400, '0, rd, st);
    chk("tp_store_hit_data", rd, 32'h12345678);
    chk("tp_store_hit_stalls", st, 0);

    do_req(2, 32'h800, 32'hDEADBEEF, rd, st);
    do_req(1, 32'h800, '0, rd, st);
    chk("tp_no_allocate_miss", st > 0, 1);
    chk("tp_no_allocate_data", rd, 32'hDEADBEEF);
    do_req(1, 32'h400, '0, rd, st);
    chk("tp_cached_before_rst", st, 0);

    fixed_delay = 6;
    read_en = 1'b1;
    address = 32'h1000;
    repeat (3) @(posedge clk);
    #1;
    chk("tp_pre_rst_r_en", sram_r_en, 1);
    rst_n   = 1'b0;
    read_en = 1'b0;
    #1;
    chk("tp_mid_rst_r_en", sram_r_en, 0);
    chk("tp_mid_rst_ready", ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fixed_delay = 0;
    do_req(1, 32'h400, '0, rd, st);
    chk("tp_after_rst_miss", st > 0, 1);

    do_reset();
    do_req(1, 32'h400, '0, rd, st);
    do_req(1, 32'h400, '0, rd, st);
    do_req(1, 32'h404, '0, rd, st);
    do_req(1, 32'h600, '0, rd, st);
    do_req(1, 32'h600, '0, rd, st);
    do_req(1, 32'h800, '0, rd, st);
    do_req(1, 32'h800, '0, rd, st);
    do_req(1, 32'h604, '0, rd, st);
    @(negedge clk);
`ifdef DCACHE_STATS_EN
    chk("tp_stats_hits", hit_count, 16'd5);
    chk("tp_stats_misses", miss_count, 16'd3);
`else
    chk("tp_stats_hits_off", hit_count, 16'd0);
    chk("tp_stats_misses_off", miss_count, 16'd0);
`endif
    @(posedge clk);
    #1;

    for (int n = 0; n < 400; n++) begin
      r    = $urandom_range(0, 9);
      kind = (r < 1) ? 0 : ((r < 4) ? 2 : 1);
      a    = BASE + ($urandom_range(0, 3) << 9) + ($urandom_range(0, 3) << 3)
             + ($urandom_range(0, 1) << 2);
      do_req(kind, a, $urandom, rd, st);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/data_cache_ctrl.md
Name: data_cache_ctrl

Overview:
- 2-way set-associative, write-through, no-write-allocate data cache between the EXE stage register (memory-stage request) and the SRAM controller.
- Replaces the direct pipeline-to-SRAM path: read hits complete in the request cycle, misses fetch a 64-bit line.
- Drives the pipeline-wide `ready` that freezes all stages while the cache is busy.

Parameters:
- BASE_ADDR, 1024, byte address of data-memory word 0; subtracted before indexing.
- SET_BITS, 6, log2 of set count (64 sets).
- TAG_BITS, 10, tag width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- address  in  32  byte address from EXE_Stage_Reg ALU result
- writeData  in  32  store data (Val_Rm)
- read_en  in  1  load request
- write_en  in  1  store request
- readData  out  32  load data to MEM_Stage_Reg
- ready  out  1  0 = pipeline must freeze
- sram_address  out  32  byte address to SRAM controller (line-aligned on reads)
- sram_wdata  out  32  store data to SRAM
- sram_r_en  out  1  line read request
- sram_w_en  out  1  word write request
- sram_rdata  in  64  line from SRAM ({word1, word0})
- sram_ready  in  1  SRAM completion pulse
- hit_count  out  16  read hits (optional feature)
- miss_count  out  16  read misses (optional feature)

Behaviour:
- Address mapping: eff = address - BASE_ADDR.
  - eff[2] selects the word in the line.
  - eff[8:3] is the index; eff[18:9] is the tag.
  - eff[1:0] ignored.
- Storage per set: way0/way1 {valid, tag[9:0], data[63:0]}, plus one LRU bit (0 = way0 least recently used).
- Reset (rst=0, async):
  - All valid and LRU bits cleared; state IDLE.
  - Outputs: sram_r_en=0, sram_w_en=0, readData=0, ready=1, counters 0.
  - Reset mid-transaction abandons it; no line fill, no cache update.
- Request priority: write_en has priority if read_en and write_en are both 1. With no request, ready=1.
- Hit = valid & tag match in either way (combinational).
- State IDLE:
  - Read hit: readData = selected word of the hit way (combinational, same cycle), ready=1. LRU bit := other way at clock edge. Stay IDLE.
  - Read miss: ready=0; next state READ_MISS.
  - Write: ready=0; next state WRITE.
- State READ_MISS:
  - Drives sram_r_en=1 and sram_address = {address[31:3], 3'b000}; ready=0 until sram_ready.
  - On the sram_ready cycle:
    - ready=1 and readData = sram_rdata word eff[2].
    - Line written into the LRU way (invalid way0 preferred, then invalid way1) with valid=1 and new tag.
    - LRU := other way; next state IDLE.
- State WRITE:
  - Drives sram_w_en=1, sram_address=address, sram_wdata=writeData; ready=0 until sram_ready.
  - On the sram_ready cycle, ready=1 and the state returns to IDLE.
  - On a hit, the matching word in the hit way is updated and LRU := other way.
  - On a miss, the cache is unchanged (no allocate).
- sram_ready is sampled only in READ_MISS/WRITE. The controller holds sram_ready=0 while an enable is asserted and the operation is incomplete.
- The request inputs stay stable while ready=0 (pipeline frozen). The cache consumes a request exactly once.
- Latency:
  - Read hit: 0 extra cycles.
  - Read miss: 1 + N cycles, where N is SRAM cycles to sram_ready.
  - Write: 1 + N cycles.
- sram_r_en/sram_w_en deassert in the cycle after sram_ready (IDLE).
- The two ways of one set never hold the same tag valid simultaneously.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined: hit_count/miss_count increment once per completed read hit/miss (miss counted on entry to READ_MISS), saturating at 16'hFFFF, cleared by rst.
- Undefined: both ports tied to 0, no counter flops.

Test Plan:
- Reset, then read 0x400 with SRAM line {0xBBBB0000,0xAAAA0000}:
  - ready=0 through READ_MISS with sram_address=0x400.
  - On sram_ready, readData=0xAAAA0000 and ready=1.
  - Repeat read 0x404 -> same-cycle hit, readData=0xBBBB0000, ready stays 1.
- Fill eff 0x000, 0x200, 0x400 (same index 0, tags 0,1,2), then read 0x000:
  - The third fill evicts tag0 (LRU way).
  - Reading tag1's address hits; reading eff 0x000 misses.
- Store 0x12345678 to cached 0x400:
  - sram_w_en=1 with sram_wdata=0x12345678 until sram_ready.
  - Subsequent read 0x400 hits with 0x12345678 and issues no SRAM read.
- Store to uncached 0x800:
  - SRAM write issued.
  - Following read 0x800 is a miss (no allocate).
- Assert rst=0 mid-READ_MISS:
  - sram_r_en drops immediately and ready=1.
  - Earlier-cached line now misses (valid cleared).
- With DCACHE_STATS_EN, 3 misses + 5 hits -> miss_count=3, hit_count=5. Without the macro, both read 0.
